// File: rtl/gba_pad_pkg.sv
// Shared definitions for the pad emulation blocks: FSM states, button slot
// positions within the 16-bit serial frame and the default pad ID nibble.
package gba_pad_pkg;

    typedef enum logic [1:0] {
        PAD_IDLE,
        PAD_LATCH,
        PAD_SHIFT,
        PAD_DONE
    } pad_state_t;

    // Slot positions within the serial frame (slot i carries buttons[i])
    localparam int PAD_B      = 0;
    localparam int PAD_Y      = 1;
    localparam int PAD_SELECT = 2;
    localparam int PAD_START  = 3;
    localparam int PAD_UP     = 4;
    localparam int PAD_DOWN   = 5;
    localparam int PAD_LEFT   = 6;
    localparam int PAD_RIGHT  = 7;
    localparam int PAD_A      = 8;
    localparam int PAD_X      = 9;
    localparam int PAD_L      = 10;
    localparam int PAD_R      = 11;

    // A genuine pad reports an all-zero ID in slots 12..15
    localparam logic [3:0] PAD_ID_DEFAULT = 4'b0000;

endpackage

// File: rtl/pad_sync_edge.sv
// Brings one asynchronous host pin into the clock domain and flags its edges.
// The last synchroniser stage is compared against a history flop, so an edge
// on the pin is visible as a one-cycle rise/fall strobe SYNC_STAGES cycles
// after it happens and acted on by the next register stage.
module pad_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic pin,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] stages;
    logic                   history;
    logic                   level;

    assign level = stages[SYNC_STAGES-1];

    // Shift the pin through the synchroniser chain and remember the previous level
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stages  <= {SYNC_STAGES{RESET_VALUE}};
            history <= RESET_VALUE;
        end else begin
            stages  <= {stages[SYNC_STAGES-2:0], pin};
            history <= level;
        end
    end

    assign rise = level & ~history;
    assign fall = ~level & history;

endmodule

// File: rtl/snes_pad_responder.sv
// Device side of the SNES pad protocol. A latch pulse from the host snapshots
// the button word (inverted, since the line is active-low) into a shift
// register; each host clock rise then moves the next slot onto serial_data.
// After the last slot the line rests at 0, as a real pad does. A stalled host
// is detected by a timeout while shifting, and short latch pulses are treated
// as glitches and dropped.
module snes_pad_responder
    import gba_pad_pkg::*;
#(
    parameter int SYNC_STAGES      = 2,
    parameter int MIN_LATCH_CYCLES = 4,
    parameter int NUM_BITS         = 16,
    parameter int TIMEOUT_CYCLES   = 4096
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        data_latch,
    input  logic        data_clock,
    input  logic [15:0] buttons,
    output logic        serial_data,
    output logic        busy,
    output logic        frame_done,
    output logic        timeout,
    output logic [4:0]  bit_idx
);

    localparam int LCNT_W = $clog2(MIN_LATCH_CYCLES + 1);
    localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [LCNT_W-1:0] LATCH_MIN    = LCNT_W'(MIN_LATCH_CYCLES);
    localparam logic [TCNT_W-1:0] TIMEOUT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [4:0]        LAST_SLOT    = 5'(NUM_BITS - 1);

    pad_state_t         state;
    logic [15:0]        shreg;
    logic [LCNT_W-1:0]  latch_cnt;
    logic [TCNT_W-1:0]  tout_cnt;

    logic latch_rise;
    logic latch_fall;
    logic clock_rise;
    logic clock_fall;

    pad_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VALUE (1'b0)
    ) u_latch_sync (
        .clock (clock),
        .reset (reset),
        .pin   (data_latch),
        .rise  (latch_rise),
        .fall  (latch_fall)
    );

    // The host clock idles high, so its synchroniser resets high to avoid a
    // phantom rise straight out of reset
    pad_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VALUE (1'b1)
    ) u_clock_sync (
        .clock (clock),
        .reset (reset),
        .pin   (data_clock),
        .rise  (clock_rise),
        .fall  (clock_fall)
    );

    // Protocol FSM with the shift register, latch-width and stall counters
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= PAD_IDLE;
            shreg      <= 16'hFFFF;
            bit_idx    <= 5'd0;
            latch_cnt  <= '0;
            tout_cnt   <= '0;
            frame_done <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            timeout    <= 1'b0;
            if (latch_rise) begin
                state     <= PAD_LATCH;
                shreg     <= ~buttons;
                latch_cnt <= LCNT_W'(1);
                bit_idx   <= 5'd0;
                tout_cnt  <= '0;
            end else begin
                case (state)
                    PAD_IDLE: begin
                        bit_idx <= 5'd0;
                    end
                    PAD_LATCH: begin
                        if (latch_fall) begin
                            latch_cnt <= '0;
                            tout_cnt  <= '0;
                            if (latch_cnt >= LATCH_MIN) begin
                                state <= PAD_SHIFT;
                            end else begin
                                state <= PAD_IDLE;
                                shreg <= 16'hFFFF;
                            end
                        end else begin
                            shreg <= ~buttons;
                            if (latch_cnt < LATCH_MIN) begin
                                latch_cnt <= latch_cnt + 1'b1;
                            end
                        end
                    end
                    PAD_SHIFT: begin
                        if (clock_rise) begin
                            shreg    <= {1'b0, shreg[15:1]};
                            bit_idx  <= bit_idx + 5'd1;
                            tout_cnt <= '0;
                            if (bit_idx == LAST_SLOT) begin
                                state      <= PAD_DONE;
                                frame_done <= 1'b1;
                            end
                        end else if (tout_cnt == TIMEOUT_LAST) begin
                            state    <= PAD_IDLE;
                            shreg    <= 16'hFFFF;
                            bit_idx  <= 5'd0;
                            tout_cnt <= '0;
                            timeout  <= 1'b1;
                        end else begin
                            tout_cnt <= tout_cnt + 1'b1;
                        end
                    end
                    PAD_DONE: begin
                        shreg <= 16'h0000;
                    end
                    default: begin
                        state <= PAD_IDLE;
                    end
                endcase
            end
        end
    end

    assign serial_data = shreg[0];
    assign busy        = (state == PAD_LATCH) || (state == PAD_SHIFT);

    // Falling host-clock edges carry no meaning on the device side
    logic unused_clock_fall;
    assign unused_clock_fall = clock_fall;

endmodule

// File: tb/tb_snes_pad_responder.sv
// Bench for the SNES pad responder: plays the host side of the protocol and
// compares the pad outputs against a frame-level model of what the line,
// busy flag and slot index must be between host events.
module tb_snes_pad_responder;

    localparam int SYNC_STAGES      = 2;
    localparam int MIN_LATCH_CYCLES = 4;
    localparam int NUM_BITS         = 16;
    localparam int TIMEOUT_CYCLES   = 4096;

    localparam int M_IDLE  = 0;
    localparam int M_SHIFT = 1;
    localparam int M_DONE  = 2;

    logic        clock;
    logic        reset;
    logic        data_latch;
    logic        data_clock;
    logic [15:0] buttons;
    logic        serial_data;
    logic        busy;
    logic        frame_done;
    logic        timeout;
    logic [4:0]  bit_idx;

    int          checks;
    int          errors;
    int          frame_cnt;
    int          timeout_cnt;
    logic        check_en;

    int          model_mode;
    int          model_slot;
    logic [15:0] model_word;

    snes_pad_responder #(
        .SYNC_STAGES      (SYNC_STAGES),
        .MIN_LATCH_CYCLES (MIN_LATCH_CYCLES),
        .NUM_BITS         (NUM_BITS),
        .TIMEOUT_CYCLES   (TIMEOUT_CYCLES)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .data_latch  (data_latch),
        .data_clock  (data_clock),
        .buttons     (buttons),
        .serial_data (serial_data),
        .busy        (busy),
        .frame_done  (frame_done),
        .timeout     (timeout),
        .bit_idx     (bit_idx)
    );

    // Free-running block clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
        end
    endtask

    function automatic logic model_line();
        if (model_mode == M_SHIFT && model_slot < NUM_BITS) return ~model_word[model_slot];
        if (model_mode == M_IDLE) return 1'b1;
        return 1'b0;
    endfunction

    // Continuous comparison against the frame-level model whenever the pad is settled
    always @(negedge clock) begin
        if (check_en && !reset) begin
            check_output("serial_data", 32'(serial_data), 32'(model_line()));
            check_output("busy", 32'(busy), 32'(model_mode == M_SHIFT));
            check_output("bit_idx", 32'(bit_idx), 32'(model_slot));
        end
    end

    // Count completion and abort pulses for the event-level checks
    always @(negedge clock) begin
        if (!reset) begin
            if (frame_done) frame_cnt++;
            if (timeout) timeout_cnt++;
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Host latch pulse of the given width; the pad snapshots the pattern
    task automatic apply_latch(input int width, input logic [15:0] pattern);
        check_en   = 1'b0;
        buttons    = pattern;
        data_latch = 1'b1;
        wait_cycles(width);
        data_latch = 1'b0;
        wait_cycles(SYNC_STAGES + 2);
        model_slot = 0;
        if (width >= MIN_LATCH_CYCLES) begin
            model_mode = M_SHIFT;
            model_word = pattern;
        end else begin
            model_mode = M_IDLE;
        end
        check_en = 1'b1;
    endtask

    // One host clock pulse: low 2 cycles, sample, then high 4 cycles
    task automatic apply_clock(input logic sample, input logic expected, input string name);
        data_clock = 1'b0;
        wait_cycles(2);
        if (sample) check_output(name, 32'(serial_data), 32'(expected));
        data_clock = 1'b1;
        check_en   = 1'b0;
        wait_cycles(SYNC_STAGES + 2);
        if (model_mode == M_SHIFT) begin
            model_slot++;
            if (model_slot == NUM_BITS) model_mode = M_DONE;
        end
        check_en = 1'b1;
    endtask

    // Full 16-slot read with the hand-computed line level of every slot
    task automatic apply_frame(input logic [15:0] expected_levels, input string tag);
        logic [15:0] levels;
        levels = expected_levels;
        for (int i = 0; i < NUM_BITS; i++) begin
            apply_clock(1'b1, levels[i], $sformatf("%s_slot%0d", tag, i));
        end
    endtask

    initial begin
        int frames_before;
        checks      = 0;
        errors      = 0;
        frame_cnt   = 0;
        timeout_cnt = 0;
        check_en    = 1'b0;
        model_mode  = M_IDLE;
        model_slot  = 0;
        model_word  = 16'h0000;
        reset       = 1'b1;
        data_latch  = 1'b0;
        data_clock  = 1'b1;
        buttons     = 16'h0000;

        // Reset state
        wait_cycles(3);
        check_output("reset_serial_data", 32'(serial_data), 32'd1);
        check_output("reset_busy", 32'(busy), 32'd0);
        check_output("reset_bit_idx", 32'(bit_idx), 32'd0);
        check_output("reset_frame_done", 32'(frame_done), 32'd0);
        check_output("reset_timeout", 32'(timeout), 32'd0);
        reset = 1'b0;
        wait_cycles(3);
        check_en = 1'b1;
        wait_cycles(5);

        // Basic frame: B and R pressed
        $display("[TB] frame with buttons 0801");
        frames_before = frame_cnt;
        apply_latch(12, 16'h0801);
        apply_frame(16'hF7FE, "b_r");
        check_output("b_r_frame_done_count", 32'(frame_cnt - frames_before), 32'd1);
        check_output("b_r_line_after_last", 32'(serial_data), 32'd0);
        check_output("b_r_bit_idx_done", 32'(bit_idx), 32'd16);

        // Extra clock in DONE is ignored
        apply_clock(1'b0, 1'b0, "done_extra");
        check_output("done_bit_idx_hold", 32'(bit_idx), 32'd16);
        check_output("done_no_extra_pulse", 32'(frame_cnt - frames_before), 32'd1);

        // Glitch latch
        $display("[TB] short latch glitch");
        frames_before = frame_cnt;
        apply_latch(2, 16'h0000);
        check_output("glitch_serial_data", 32'(serial_data), 32'd1);
        check_output("glitch_busy", 32'(busy), 32'd0);
        check_output("glitch_no_frame_done", 32'(frame_cnt - frames_before), 32'd0);
        wait_cycles(5);

        // Minimum-width latch is accepted
        apply_latch(MIN_LATCH_CYCLES, 16'h8000);
        check_output("min_latch_busy", 32'(busy), 32'd1);
        apply_frame(16'h7FFF, "min_latch");

        // Re-latch mid-frame, with buttons changed during the old frame
        $display("[TB] re-latch after 5 shifts");
        frames_before = frame_cnt;
        apply_latch(12, 16'h0801);
        for (int i = 0; i < 5; i++) begin
            apply_clock(1'b0, 1'b0, "relatch_old");
            if (i == 1) buttons = 16'h1234;
        end
        check_output("relatch_old_idx", 32'(bit_idx), 32'd5);
        check_output("relatch_old_no_done", 32'(frame_cnt - frames_before), 32'd0);
        apply_latch(12, 16'hFFFF);
        apply_frame(16'h0000, "relatch_new");
        check_output("relatch_frame_done_count", 32'(frame_cnt - frames_before), 32'd1);

        // Latch and clock rise together: latch wins, new frame starts at slot 0
        $display("[TB] simultaneous latch and clock rise");
        apply_latch(12, 16'h0801);
        apply_clock(1'b0, 1'b0, "simul_pre0");
        apply_clock(1'b0, 1'b0, "simul_pre1");
        data_clock = 1'b0;
        wait_cycles(2);
        check_en   = 1'b0;
        data_latch = 1'b1;
        data_clock = 1'b1;
        wait_cycles(8);
        data_latch = 1'b0;
        wait_cycles(SYNC_STAGES + 2);
        model_mode = M_SHIFT;
        model_slot = 0;
        model_word = 16'h0801;
        check_en   = 1'b1;
        check_output("simul_bit_idx", 32'(bit_idx), 32'd0);
        apply_frame(16'hF7FE, "simul");

        // Stalled host: timeout after three shifts
        $display("[TB] host stall timeout");
        frames_before = frame_cnt;
        apply_latch(12, 16'h00F0);
        for (int i = 0; i < 3; i++) apply_clock(1'b0, 1'b0, "tout_shift");
        wait_cycles(TIMEOUT_CYCLES - 50);
        check_output("tout_not_yet", 32'(timeout_cnt), 32'd0);
        check_en = 1'b0;
        wait_cycles(100);
        model_mode = M_IDLE;
        model_slot = 0;
        check_en   = 1'b1;
        check_output("tout_pulse_count", 32'(timeout_cnt), 32'd1);
        check_output("tout_serial_data", 32'(serial_data), 32'd1);
        check_output("tout_bit_idx", 32'(bit_idx), 32'd0);
        check_output("tout_no_frame_done", 32'(frame_cnt - frames_before), 32'd0);
        wait_cycles(5);

        // Asynchronous reset mid-frame
        $display("[TB] reset during shift");
        apply_latch(12, 16'h0801);
        for (int i = 0; i < 7; i++) apply_clock(1'b0, 1'b0, "rst_shift");
        check_output("rst_pre_idx", 32'(bit_idx), 32'd7);
        check_en = 1'b0;
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        check_output("rst_async_serial_data", 32'(serial_data), 32'd1);
        check_output("rst_async_busy", 32'(busy), 32'd0);
        check_output("rst_async_bit_idx", 32'(bit_idx), 32'd0);
        wait_cycles(3);
        reset      = 1'b0;
        model_mode = M_IDLE;
        model_slot = 0;
        check_en   = 1'b1;
        wait_cycles(5);
        frames_before = frame_cnt;
        apply_latch(12, 16'h00F0);
        apply_frame(16'hFF0F, "post_rst");
        check_output("post_rst_frame_done", 32'(frame_cnt - frames_before), 32'd1);
        check_output("timeout_total", 32'(timeout_cnt), 32'd1);

        wait_cycles(5);
        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/snes_pad_responder.md
Name: snes_pad_responder

Overview:
- Device end of the SNES controller serial protocol: emulates the pad that the `controller` host interface polls.
- Used in loopback rigs and on the board, with the JA pins wired so `controller` reads this block.
- Takes a 16-bit button word and answers latch/clock polling from the host on an active-low serial line, bit-compatible with a genuine pad.
- Host inputs are asynchronous and synchronized internally.

Parameters:
SYNC_STAGES, 2, flip-flop stages on data_latch and data_clock (minimum 2)
MIN_LATCH_CYCLES, 4, minimum synchronized latch-high width in clock cycles; shorter pulses are glitches
NUM_BITS, 16, serial slots per frame
TIMEOUT_CYCLES, 4096, clock cycles without a data_clock rising edge in SHIFT before the frame is abandoned

Ports:
clock  input  1  block clock; all state is on its rising edge
reset  input  1  asynchronous, active-high reset
data_latch  input  1  host latch, asynchronous, active-high
data_clock  input  1  host shift clock, asynchronous, idles high
buttons  input  16  pressed=1, synchronous to clock; slot i carries buttons[i] (B,Y,Sel,Start,Up,Dn,L,R,A,X,L,R,ID3..0)
serial_data  output  1  pad data line, active-low (pressed drives 0)
busy  output  1  high in LATCH or SHIFT
frame_done  output  1  one-cycle pulse when slot NUM_BITS-1 has been shifted out
timeout  output  1  one-cycle pulse on SHIFT timeout abort
bit_idx  output  5  index of the slot currently driven on serial_data

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, shreg=16'hFFFF, serial_data=1, bit_idx=0.
  - busy=0, frame_done=0, timeout=0; latch counter and timeout counter = 0.
- Synchronizers:
  - data_latch and data_clock each pass through SYNC_STAGES flops plus one history flop.
  - rise/fall = current synchronized value compared with the history flop.
  - A pin edge is acted on SYNC_STAGES+1 clock cycles after it occurs.
- serial_data is always shreg[0], registered; no combinational path from the pins.
- IDLE: line 1; waits for a latch rise.
- LATCH (entered on a latch rise from any state, which aborts any frame in progress):
  - Every cycle: shreg <= ~buttons, latch counter increments (saturating), bit_idx=0.
  - data_clock edges are ignored; parallel load dominates.
  - On latch fall with counter >= MIN_LATCH_CYCLES: go to SHIFT; the snapshot is the value loaded in that last cycle.
  - On latch fall with counter < MIN_LATCH_CYCLES: glitch; go to IDLE with shreg <= 16'hFFFF.
- SHIFT:
  - On each data_clock rise: shreg <= {1'b0, shreg[15:1]}, bit_idx++, timeout counter cleared.
  - When the rise that advances bit_idx past NUM_BITS-1 occurs: go to DONE and pulse frame_done in that cycle.
  - The line is then 0, matching a real pad that returns "1" after slot 15.
  - If the timeout counter reaches TIMEOUT_CYCLES: go to IDLE, shreg <= 16'hFFFF, pulse timeout.
- DONE: line stays 0; further clock rises are ignored (bit_idx holds at NUM_BITS); only a latch rise leaves.
- Simultaneous latch rise and clock rise in the same synchronized cycle: latch wins.
- buttons changes: only the value present on the last LATCH cycle is transmitted; changes during SHIFT are invisible until the next latch.
- Counters saturate and never wrap; bit_idx width is 5 so NUM_BITS=16 fits without overflow.

Decomposition:
- Shared package gba_pad_pkg:
  - typedef enum logic [1:0] {PAD_IDLE, PAD_LATCH, PAD_SHIFT, PAD_DONE} pad_state_t;
  - slot index constants PAD_B=0 … PAD_R=11;
  - PAD_ID_DEFAULT = 4'b0000.
- Sub-module `pad_sync_edge` (SYNC_STAGES synchronizer plus rise/fall detect) instantiated twice.
- The FSM, shift register and counters stay in the top of the block.

Test Plan:
- buttons=16'h0801 (B, R), 12-cycle latch, 16 clock pulses of 6 cycles each:
  - host samples slots 0..15 after each fall as 0,1,1,1,1,1,1,1,1,1,1,0,1,1,1,1 (line levels);
  - frame_done pulses once; serial_data=0 after the final rise.
- Latch pulse of 2 synchronized cycles (< MIN_LATCH_CYCLES) → IDLE, serial_data=1, no frame_done, busy low within SYNC_STAGES+2 cycles.
- Re-latch after 5 of 16 shifts with buttons=16'hFFFF → line 0 for all 16 slots of the new frame; the old frame never raises frame_done.
- 3 shifts then data_clock held high for 4096+ cycles → timeout pulses once, state IDLE, serial_data=1, bit_idx=0.
- Reset asserted mid-SHIFT (bit_idx=7) asynchronously → serial_data=1 and busy=0 immediately; after release the next latch runs a normal frame.
- Loopback: instantiate `controller` as host with buttons=16'h00F0 → the host's buttons output equals 16'h00F0 over 3 consecutive polls.
